wb_breathe_pwm: RTL and testbench

- Wishbone-slave PWM/breathe engine with NUM_CH LED channels.
- Sits directly downstream of the AHB-to-FPGA Wishbone bridge, inside the composite FPGA IP, behind the IP's address decode.
- Decoded WBs_* cycles program per-channel duty, enable and breathe rate; the block drives pwm_o to io_pad outputs.
- Static-duty mode: fixed 8-bit duty cycle. Breathe mode: triangular ramp of the duty cycle.

---
 rtl/wb_breathe_pwm_pkg.sv | 21 ++
 rtl/wb_breathe_pwm_if.sv | 23 ++
 rtl/wb_breathe_pwm_breathe_chan.sv | 72 +++++++
 rtl/wb_breathe_pwm.sv | 132 +++++++++++++
 tb/tb_wb_breathe_pwm.sv | 313 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/wb_breathe_pwm_pkg.sv
// Shared register map, control bit positions and channel FSM encoding
// for the Wishbone PWM/breathe engine.
package wb_breathe_pwm_pkg;

  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_PRESC  = 2'd1;
  localparam logic [1:0] REG_STATUS = 2'd2;

  localparam int CTRL_EN_BIT   = 0;
  localparam int CTRL_BRTH_BIT = 1;
  localparam int CTRL_DUTY_LSB = 8;

  localparam logic [7:0] PWM_PERIOD = 8'd255;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    UP   = 2'd1,
    DOWN = 2'd2
  } brth_state_e;

endpackage

// File: rtl/wb_breathe_pwm_if.sv
// Decoded Wishbone slave bus as seen by the PWM engine.
interface wb_breathe_pwm_if #(
  parameter int ADDRWIDTH = 4
);
  logic [ADDRWIDTH-1:0] WBs_ADR;
  logic                 WBs_CYC;
  logic [3:0]           WBs_BYTE_STB;
  logic                 WBs_WE;
  logic                 WBs_STB;
  logic [31:0]          WBs_WR_DAT;
  logic [31:0]          WBs_RD_DAT;
  logic                 WBs_ACK;

  modport master (
    output WBs_ADR, WBs_CYC, WBs_BYTE_STB, WBs_WE, WBs_STB, WBs_WR_DAT,
    input  WBs_RD_DAT, WBs_ACK
  );

  modport slave (
    input  WBs_ADR, WBs_CYC, WBs_BYTE_STB, WBs_WE, WBs_STB, WBs_WR_DAT,
    output WBs_RD_DAT, WBs_ACK
  );
endinterface

// File: rtl/wb_breathe_pwm_breathe_chan.sv
// One PWM channel: static duty or triangular breathe ramp of the level,
// compared against the shared counter to give a registered PWM output.
module breathe_chan
  import wb_breathe_pwm_pkg::*;
#(
  parameter int PRESC_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               brth,
  input  logic [7:0]         duty,
  input  logic [PRESC_W-1:0] presc,
  input  logic [7:0]         pwm_cnt,
  output logic               pwm,
  output logic [7:0]         level,
  output logic               dir,
  output brth_state_e        state
);

  brth_state_e        state_q;
  logic [7:0]         level_q;
  logic [PRESC_W-1:0] pcnt_q;
  logic               pwm_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      level_q <= 8'd0;
      pcnt_q  <= '0;
      pwm_q   <= 1'b0;
    end else begin
      pwm_q <= en && (pwm_cnt < level_q);
      case (state_q)
        IDLE: begin
          pcnt_q <= '0;
          if (en && brth) begin
            state_q <= UP;
            level_q <= 8'd0;
          end else begin
            level_q <= duty;
          end
        end
        default: begin
          if (!(en && brth)) begin
            state_q <= IDLE;
            level_q <= duty;
            pcnt_q  <= '0;
          end else if (pcnt_q >= presc) begin
            // >= rather than == so a shrinking prescale never stalls the ramp
            pcnt_q <= '0;
            if (state_q == UP) begin
              level_q <= level_q + 8'd1;
              if (level_q == 8'd254) state_q <= DOWN;
            end else begin
              level_q <= level_q - 8'd1;
              if (level_q == 8'd1) state_q <= UP;
            end
          end else begin
            pcnt_q <= pcnt_q + 1'b1;
          end
        end
      endcase
    end
  end

  assign pwm   = pwm_q;
  assign level = level_q;
  assign dir   = (state_q == DOWN);
  assign state = state_q;

endmodule

// File: rtl/wb_breathe_pwm.sv
// Wishbone register file, single-cycle-delayed ACK and read mux, shared
// 255-clock PWM counter, and NUM_CH breathe_chan instances.
module wb_breathe_pwm
  import wb_breathe_pwm_pkg::*;
#(
  parameter int NUM_CH    = 4,
  parameter int ADDRWIDTH = 4,
  parameter int PRESC_W   = 16
) (
  input  logic              WB_CLK,
  input  logic              WB_RST,
  wb_breathe_pwm_if.slave   wb,
  output logic [NUM_CH-1:0] pwm_o
);

  logic [NUM_CH-1:0]  en_q, en_d;
  logic [NUM_CH-1:0]  brth_q, brth_d;
  logic [7:0]         duty_q  [NUM_CH];
  logic [7:0]         duty_d  [NUM_CH];
  logic [PRESC_W-1:0] presc_q [NUM_CH];
  logic [PRESC_W-1:0] presc_d [NUM_CH];
  logic               ack_q, ack_d;
  logic [31:0]        rd_dat_q, rd_dat_d;
  logic [7:0]         pwm_cnt_q, pwm_cnt_d;

  logic [7:0]         level_w [NUM_CH];
  logic [NUM_CH-1:0]  dir_w;
  brth_state_e        state_w [NUM_CH];

  logic        req;
  logic        addr_ok;
  logic [1:0]  ch;
  logic [1:0]  rg;
  logic [31:0] be_mask;
  logic [31:0] rd_mux;
  logic        unused_wr_dat;

  generate
    if (ADDRWIDTH > 4) begin : g_hi_dec
      assign addr_ok = ~|wb.WBs_ADR[ADDRWIDTH-1:4];
    end else begin : g_no_hi
      assign addr_ok = 1'b1;
    end
  endgenerate

  assign unused_wr_dat = ^wb.WBs_WR_DAT;

  always_comb begin
    req     = wb.WBs_CYC & wb.WBs_STB & ~ack_q;
    ch      = wb.WBs_ADR[3:2];
    rg      = wb.WBs_ADR[1:0];
    be_mask = {{8{wb.WBs_BYTE_STB[3]}}, {8{wb.WBs_BYTE_STB[2]}},
               {8{wb.WBs_BYTE_STB[1]}}, {8{wb.WBs_BYTE_STB[0]}}};
    en_d    = en_q;
    brth_d  = brth_q;
    duty_d  = duty_q;
    presc_d = presc_q;
    rd_mux  = 32'd0;

    for (int i = 0; i < NUM_CH; i++) begin
      if (addr_ok && ch == 2'(i)) begin
        if (req && wb.WBs_WE) begin
          if (rg == REG_CTRL) begin
            if (wb.WBs_BYTE_STB[0]) begin
              en_d[i]   = wb.WBs_WR_DAT[CTRL_EN_BIT];
              brth_d[i] = wb.WBs_WR_DAT[CTRL_BRTH_BIT];
            end
            if (wb.WBs_BYTE_STB[1])
              duty_d[i] = wb.WBs_WR_DAT[CTRL_DUTY_LSB +: 8];
          end else if (rg == REG_PRESC) begin
            presc_d[i] = (presc_q[i] & ~be_mask[PRESC_W-1:0]) |
                         (wb.WBs_WR_DAT[PRESC_W-1:0] & be_mask[PRESC_W-1:0]);
          end
        end
        case (rg)
          REG_CTRL:   rd_mux = {16'd0, duty_q[i], 6'd0, brth_q[i], en_q[i]};
          REG_PRESC:  rd_mux = 32'(presc_q[i]);
          REG_STATUS: rd_mux = {21'd0, 2'(state_w[i]), dir_w[i], level_w[i]};
          default:    rd_mux = 32'd0;
        endcase
      end
    end

    ack_d     = req;
    rd_dat_d  = req ? rd_mux : rd_dat_q;
    pwm_cnt_d = (pwm_cnt_q == PWM_PERIOD - 8'd1) ? 8'd0 : pwm_cnt_q + 8'd1;
  end

  always_ff @(posedge WB_CLK or posedge WB_RST) begin
    if (WB_RST) begin
      en_q      <= '0;
      brth_q    <= '0;
      ack_q     <= 1'b0;
      rd_dat_q  <= 32'd0;
      pwm_cnt_q <= 8'd0;
      for (int i = 0; i < NUM_CH; i++) begin
        duty_q[i]  <= 8'd0;
        presc_q[i] <= '0;
      end
    end else begin
      en_q      <= en_d;
      brth_q    <= brth_d;
      ack_q     <= ack_d;
      rd_dat_q  <= rd_dat_d;
      pwm_cnt_q <= pwm_cnt_d;
      duty_q    <= duty_d;
      presc_q   <= presc_d;
    end
  end

  assign wb.WBs_ACK    = ack_q;
  assign wb.WBs_RD_DAT = rd_dat_q;

  generate
    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      breathe_chan #(.PRESC_W(PRESC_W)) u_chan (
        .clk     (WB_CLK),
        .rst     (WB_RST),
        .en      (en_q[g]),
        .brth    (brth_q[g]),
        .duty    (duty_q[g]),
        .presc   (presc_q[g]),
        .pwm_cnt (pwm_cnt_q),
        .pwm     (pwm_o[g]),
        .level   (level_w[g]),
        .dir     (dir_w[g]),
        .state   (state_w[g])
      );
    end
  endgenerate

endmodule

// File: tb/tb_wb_breathe_pwm.sv
// Directed bench for wb_breathe_pwm: register access, PWM duty, breathe ramp timing.
module tb_wb_breathe_pwm;

  logic       WB_CLK = 1'b0;
  logic       WB_RST = 1'b1;
  logic [3:0] pwm_o;
  int         vectors = 0;
  int         miscompares = 0;
  int         cyc_cnt = 0;

  logic [31:0] rd;
  logic        a1, a2;
  int          c1;
  int          hi;

  wb_breathe_pwm_if #(.ADDRWIDTH(4)) wb ();

  wb_breathe_pwm #(.NUM_CH(4), .ADDRWIDTH(4), .PRESC_W(16)) dut (
    .WB_CLK (WB_CLK),
    .WB_RST (WB_RST),
    .wb     (wb),
    .pwm_o  (pwm_o)
  );

  always #5 WB_CLK = ~WB_CLK;
  always @(posedge WB_CLK) cyc_cnt <= cyc_cnt + 1;

  initial begin
    #600000;
    $display("FAIL watchdog: run still active at %0t, required finish", $time);
    $fatal(1, "watchdog");
  end

  // One transfer: request edge, then the following edge; returns 1ns after the latter.
  task automatic bus(input logic we, input logic [1:0] ch, input logic [1:0] rg,
                     input logic [31:0] dat, input logic [3:0] be,
                     output logic [31:0] rdat, output logic ack1, output logic ack2);
    @(negedge WB_CLK);
    wb.WBs_ADR      = {ch, rg};
    wb.WBs_CYC      = 1'b1;
    wb.WBs_STB      = 1'b1;
    wb.WBs_WE       = we;
    wb.WBs_WR_DAT   = dat;
    wb.WBs_BYTE_STB = be;
    @(posedge WB_CLK); #1;
    ack1 = wb.WBs_ACK;
    rdat = wb.WBs_RD_DAT;
    wb.WBs_CYC = 1'b0;
    wb.WBs_STB = 1'b0;
    wb.WBs_WE  = 1'b0;
    @(posedge WB_CLK); #1;
    ack2 = wb.WBs_ACK;
  endtask

  task automatic wait_cyc(input int target);
    while (cyc_cnt < target) begin
      @(posedge WB_CLK); #1;
    end
  endtask

  task automatic count_high(input int ch, output int n);
    n = 0;
    for (int k = 0; k < 255; k++) begin
      @(negedge WB_CLK);
      if (pwm_o[ch]) n++;
    end
  endtask

  task automatic test_reset();
    #1;
    vectors++;
    if (pwm_o !== 4'b0000 || wb.WBs_ACK !== 1'b0 || wb.WBs_RD_DAT !== 32'd0) begin
      miscompares++;
      $display("FAIL reset_outputs: pwm=%b ack=%b rd=%h, required 0/0/0", pwm_o, wb.WBs_ACK, wb.WBs_RD_DAT);
    end
    repeat (3) @(negedge WB_CLK);
    WB_RST = 1'b0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 3; r++) begin
        bus(1'b0, 2'(c), 2'(r), 32'd0, 4'hF, rd, a1, a2);
        vectors++;
        if (rd !== 32'd0 || a1 !== 1'b1 || a2 !== 1'b0) begin
          miscompares++;
          $display("FAIL reset_read ch%0d reg%0d: rd=%h ack=%b%b, required 0 ack=10", c, r, rd, a1, a2);
        end
      end
    end
  endtask

  task automatic test_static_duty();
    bus(1'b1, 2'd0, 2'd0, 32'h0000_4001, 4'hF, rd, a1, a2);
    repeat (4) @(posedge WB_CLK);
    count_high(0, hi);
    vectors++;
    if (hi != 64) begin
      miscompares++;
      $display("FAIL static_duty40: high=%0d, required 64", hi);
    end
    bus(1'b0, 2'd0, 2'd2, 32'd0, 4'hF, rd, a1, a2);
    vectors++;
    if (rd !== 32'h0000_0040) begin
      miscompares++;
      $display("FAIL static_status: rd=%h, required 00000040", rd);
    end
    bus(1'b0, 2'd0, 2'd0, 32'd0, 4'hF, rd, a1, a2);
    vectors++;
    if (rd !== 32'h0000_4001) begin
      miscompares++;
      $display("FAIL static_ctrl_rb: rd=%h, required 00004001", rd);
    end
  endtask

  task automatic test_duty_edges();
    logic [31:0] ctrl_v [3];
    int          exp_hi [3];
    ctrl_v[0] = 32'h0000_FF01; exp_hi[0] = 255;
    ctrl_v[1] = 32'h0000_0001; exp_hi[1] = 0;
    ctrl_v[2] = 32'h0000_FF00; exp_hi[2] = 0;
    for (int v = 0; v < 3; v++) begin
      bus(1'b1, 2'd0, 2'd0, ctrl_v[v], 4'hF, rd, a1, a2);
      repeat (4) @(posedge WB_CLK);
      count_high(0, hi);
      vectors++;
      if (hi != exp_hi[v]) begin
        miscompares++;
        $display("FAIL duty_edge ctrl=%h: high=%0d, required %0d", ctrl_v[v], hi, exp_hi[v]);
      end
    end
  endtask

  task automatic test_breathe();
    int          off [8];
    logic [31:0] exp [8];
    // PRESC=0: one step per clock from level 0 after entering UP
    off[0] = 250;  exp[0] = 32'h0000_02FA;
    off[1] = 255;  exp[1] = 32'h0000_05FF;
    off[2] = 300;  exp[2] = 32'h0000_05D2;
    off[3] = 510;  exp[3] = 32'h0000_0200;
    // PRESC=3: one step every 4 clocks, 2040-clock period
    off[4] = 1020; exp[4] = 32'h0000_05FF;
    off[5] = 2036; exp[5] = 32'h0000_0501;
    off[6] = 2040; exp[6] = 32'h0000_0200;
    off[7] = 8;    exp[7] = 32'h0000_0202;
    bus(1'b1, 2'd1, 2'd1, 32'd0, 4'hF, rd, a1, a2);
    bus(1'b1, 2'd1, 2'd0, 32'h0000_0003, 4'hF, rd, a1, a2);
    c1 = cyc_cnt;
    for (int k = 0; k < 4; k++) begin
      wait_cyc(c1 + off[k]);
      bus(1'b0, 2'd1, 2'd2, 32'd0, 4'hF, rd, a1, a2);
      vectors++;
      if (rd !== exp[k]) begin
        miscompares++;
        $display("FAIL breathe_p0 +%0d: status=%h, required %h", off[k], rd, exp[k]);
      end
    end
    bus(1'b1, 2'd1, 2'd0, 32'd0, 4'hF, rd, a1, a2);
    bus(1'b1, 2'd1, 2'd1, 32'd3, 4'hF, rd, a1, a2);
    bus(1'b1, 2'd1, 2'd0, 32'h0000_0003, 4'hF, rd, a1, a2);
    c1 = cyc_cnt;
    wait_cyc(c1 + off[7]);
    bus(1'b0, 2'd1, 2'd2, 32'd0, 4'hF, rd, a1, a2);
    vectors++;
    if (rd !== exp[7]) begin
      miscompares++;
      $display("FAIL breathe_p3 +%0d: status=%h, required %h", off[7], rd, exp[7]);
    end
    for (int k = 4; k < 7; k++) begin
      wait_cyc(c1 + off[k]);
      bus(1'b0, 2'd1, 2'd2, 32'd0, 4'hF, rd, a1, a2);
      vectors++;
      if (rd !== exp[k]) begin
        miscompares++;
        $display("FAIL breathe_p3 +%0d: status=%h, required %h", off[k], rd, exp[k]);
      end
    end
  endtask

  task automatic test_byte_strobes();
    bus(1'b1, 2'd2, 2'd0, 32'hFFFF_FFFF, 4'b0001, rd, a1, a2);
    bus(1'b0, 2'd2, 2'd0, 32'd0, 4'hF, rd, a1, a2);
    vectors++;
    if (rd !== 32'h0000_0003) begin
      miscompares++;
      $display("FAIL bstb_lane0: ctrl=%h, required 00000003", rd);
    end
    bus(1'b1, 2'd2, 2'd0, 32'hFFFF_FFFF, 4'b0010, rd, a1, a2);
    bus(1'b0, 2'd2, 2'd0, 32'd0, 4'hF, rd, a1, a2);
    vectors++;
    if (rd !== 32'h0000_FF03) begin
      miscompares++;
      $display("FAIL bstb_lane1: ctrl=%h, required 0000FF03", rd);
    end
    bus(1'b1, 2'd2, 2'd1, 32'hFFFF_FFFF, 4'b0001, rd, a1, a2);
    bus(1'b0, 2'd2, 2'd1, 32'd0, 4'hF, rd, a1, a2);
    vectors++;
    if (rd !== 32'h0000_00FF) begin
      miscompares++;
      $display("FAIL bstb_presc: presc=%h, required 000000FF", rd);
    end
    bus(1'b1, 2'd2, 2'd3, 32'hFFFF_FFFF, 4'hF, rd, a1, a2);
    vectors++;
    if (a1 !== 1'b1) begin
      miscompares++;
      $display("FAIL reserved_wr_ack: ack=%b, required 1", a1);
    end
    bus(1'b0, 2'd2, 2'd3, 32'd0, 4'hF, rd, a1, a2);
    vectors++;
    if (rd !== 32'd0) begin
      miscompares++;
      $display("FAIL reserved_rd: rd=%h, required 0", rd);
    end
    bus(1'b1, 2'd2, 2'd0, 32'd0, 4'hF, rd, a1, a2);
  endtask

  task automatic test_back_to_back();
    logic exp_ack [4];
    exp_ack[0] = 1'b1; exp_ack[1] = 1'b0; exp_ack[2] = 1'b1; exp_ack[3] = 1'b0;
    @(negedge WB_CLK);
    wb.WBs_ADR = {2'd1, 2'd1};
    wb.WBs_CYC = 1'b1;
    wb.WBs_STB = 1'b1;
    wb.WBs_WE  = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(posedge WB_CLK); #1;
      vectors++;
      if (wb.WBs_ACK !== exp_ack[k]) begin
        miscompares++;
        $display("FAIL b2b_ack cycle%0d: ack=%b, required %b", k, wb.WBs_ACK, exp_ack[k]);
      end
      if (k == 0) begin
        vectors++;
        if (wb.WBs_RD_DAT !== 32'd3) begin
          miscompares++;
          $display("FAIL b2b_rdat: rd=%h, required 00000003", wb.WBs_RD_DAT);
        end
      end
    end
    wb.WBs_CYC = 1'b0;
    wb.WBs_STB = 1'b0;
    @(posedge WB_CLK); #1;
  endtask

  task automatic test_mid_events();
    bus(1'b1, 2'd3, 2'd1, 32'd1000, 4'hF, rd, a1, a2);
    bus(1'b1, 2'd3, 2'd0, 32'h0000_0003, 4'hF, rd, a1, a2);
    c1 = cyc_cnt;
    wait_cyc(c1 + 400);
    bus(1'b0, 2'd3, 2'd2, 32'd0, 4'hF, rd, a1, a2);
    vectors++;
    if (rd !== 32'h0000_0200) begin
      miscompares++;
      $display("FAIL presc1000_nostep: status=%h, required 00000200", rd);
    end
    wait_cyc(c1 + 500);
    bus(1'b1, 2'd3, 2'd1, 32'd2, 4'hF, rd, a1, a2);
    bus(1'b0, 2'd3, 2'd2, 32'd0, 4'hF, rd, a1, a2);
    vectors++;
    if (rd !== 32'h0000_0201) begin
      miscompares++;
      $display("FAIL presc_cut_step: status=%h, required 00000201", rd);
    end
    bus(1'b1, 2'd0, 2'd0, 32'h0000_FF01, 4'hF, rd, a1, a2);
    repeat (4) @(posedge WB_CLK);
    @(negedge WB_CLK);
    vectors++;
    if (pwm_o[0] !== 1'b1) begin
      miscompares++;
      $display("FAIL pre_reset_pwm: pwm0=%b, required 1", pwm_o[0]);
    end
    #2 WB_RST = 1'b1;
    #1;
    vectors++;
    if (pwm_o !== 4'b0000 || wb.WBs_RD_DAT !== 32'd0) begin
      miscompares++;
      $display("FAIL async_reset: pwm=%b rd=%h, required 0000/0", pwm_o, wb.WBs_RD_DAT);
    end
    @(negedge WB_CLK);
    WB_RST = 1'b0;
    for (int r = 0; r < 3; r++) begin
      bus(1'b0, 2'd3, 2'(r), 32'd0, 4'hF, rd, a1, a2);
      vectors++;
      if (rd !== 32'd0) begin
        miscompares++;
        $display("FAIL post_reset ch3 reg%0d: rd=%h, required 0", r, rd);
      end
    end
    bus(1'b0, 2'd0, 2'd0, 32'd0, 4'hF, rd, a1, a2);
    vectors++;
    if (rd !== 32'd0) begin
      miscompares++;
      $display("FAIL post_reset ch0 ctrl: rd=%h, required 0", rd);
    end
  endtask

  initial begin
    wb.WBs_ADR      = '0;
    wb.WBs_CYC      = 1'b0;
    wb.WBs_STB      = 1'b0;
    wb.WBs_WE       = 1'b0;
    wb.WBs_WR_DAT   = 32'd0;
    wb.WBs_BYTE_STB = 4'h0;
    test_reset();
    test_static_duty();
    test_duty_edges();
    test_breathe();
    test_byte_strobes();
    test_back_to_back();
    test_mid_events();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
